// File: rtl/alt_ddrx_timing_pkg.sv
// Shared DDR3 command-timing constants and helpers.
//   T_CCD_BL8         : same-direction column spacing for BL8, mem clocks
//   BL8_HALF          : burst-length term in the write-to-read gap
//   RD2WR_EXTRA       : bus-turnaround pad in the read-to-write gap
//   mem2ctl_cycles()  : mem-clock count -> controller-clock count, rounded up
package alt_ddrx_timing_pkg;

  localparam int GAP_CNT_WIDTH_DEF = 6;
  localparam int T_CCD_BL8         = 4;
  localparam int BL8_HALF          = 4;
  localparam int RD2WR_EXTRA       = 2;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Half rate packs two mem clocks per ctl clock; round up so a gap is
  // never shortened.
  function automatic int unsigned mem2ctl_cycles(input int unsigned t,
                                                 input int unsigned ratio);
    return (ratio == 4) ? ((t + 1) >> 1) : t;
  endfunction

endpackage

// File: rtl/alt_ddrx_gap_counter.sv
// Loadable down-counter that holds at zero.
//   clk, rst  : clock, asynchronous active-high reset (clears to 0)
//   load      : take load_val this cycle (wins over decrement)
//   load_val  : value to load
//   zero      : count is 0 (registered state, combinational compare)
module alt_ddrx_gap_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alt_ddrx_ddr3_rdwr_turnaround.sv
// DDR3 read/write command-timing gate in front of the ODT generator.
// Holds arbiter requests until tCCD and the WR->RD / RD->WR turnaround
// gaps have elapsed, then emits a single-cycle do_write / do_read.
//   ctl_clk, ctl_reset         : clock, asynchronous active-high reset
//   mem_tcl/cas_wr_lat/twtr    : CL, CWL, tWTR in mem clocks (quasi-static)
//   cmd_valid, cmd_is_write    : request from arbiter
//   cmd_ready                  : request of the presented direction may go now
//   do_write, do_read          : issue pulses
//   turnaround_busy            : opposite-direction gap still counting
module alt_ddrx_ddr3_rdwr_turnaround
  import alt_ddrx_timing_pkg::*;
#(
  parameter int DWIDTH_RATIO         = 2,
  parameter int TCL_BUS_WIDTH        = 4,
  parameter int CAS_WR_LAT_BUS_WIDTH = 4,
  parameter int TWTR_BUS_WIDTH       = 4,
  parameter int GAP_CNT_WIDTH        = GAP_CNT_WIDTH_DEF
) (
  input  logic                            ctl_clk,
  input  logic                            ctl_reset,
  input  logic [TCL_BUS_WIDTH-1:0]        mem_tcl,
  input  logic [CAS_WR_LAT_BUS_WIDTH-1:0] mem_cas_wr_lat,
  input  logic [TWTR_BUS_WIDTH-1:0]       mem_twtr,
  input  logic                            cmd_valid,
  input  logic                            cmd_is_write,
  output logic                            cmd_ready,
  output logic                            do_write,
  output logic                            do_read,
  output logic                            turnaround_busy
);

  typedef logic [GAP_CNT_WIDTH-1:0] gap_t;
  localparam int unsigned GMAX = (32'd1 << GAP_CNT_WIDTH) - 32'd1;

  function automatic int unsigned satu(input int unsigned v);
    return (v > GMAX) ? GMAX : v;
  endfunction

  // max(a,b)-1, floored at 0 (thresholds are 0 straight out of reset)
  function automatic gap_t load_of(input gap_t a, input gap_t b);
    gap_t m;
    m = (a > b) ? a : b;
    return (m == '0) ? '0 : m - gap_t'(1);
  endfunction

  gap_t n_ccd_d, n_ccd_q, n_wr2rd_d, n_wr2rd_q, n_rd2wr_d, n_rd2wr_q;
  dir_e last_dir_d, last_dir_q;

  int unsigned cl_i, cwl_i, twtr_i, t_wr2rd, rd_sum, t_rd2wr;

  // Threshold computation in mem clocks, then converted to ctl clocks.
  always_comb begin
    cl_i    = 32'(mem_tcl);
    cwl_i   = 32'(mem_cas_wr_lat);
    twtr_i  = 32'(mem_twtr);
    t_wr2rd = satu(cwl_i + BL8_HALF + twtr_i);
    rd_sum  = satu(cl_i + BL8_HALF + RD2WR_EXTRA);
    // CL+6-CWL, clamped up to tCCD instead of wrapping when CWL is large
    t_rd2wr = (rd_sum < cwl_i + T_CCD_BL8) ? T_CCD_BL8 : rd_sum - cwl_i;
    n_ccd_d   = gap_t'(satu(mem2ctl_cycles(T_CCD_BL8, DWIDTH_RATIO)));
    n_wr2rd_d = gap_t'(satu(mem2ctl_cycles(t_wr2rd, DWIDTH_RATIO)));
    n_rd2wr_d = gap_t'(satu(mem2ctl_cycles(t_rd2wr, DWIDTH_RATIO)));
  end

  logic wr_zero, rd_zero, issue;
  gap_t wr_ld_val, rd_ld_val;

  always_comb begin
    cmd_ready  = cmd_is_write ? wr_zero : rd_zero;
    do_write   = cmd_valid & cmd_ready & cmd_is_write;
    do_read    = cmd_valid & cmd_ready & ~cmd_is_write;
    issue      = do_write | do_read;
    // Both counters reload on any issue: same class gets tCCD, the other
    // class gets the larger of tCCD and the turnaround gap.
    wr_ld_val  = do_write ? load_of(n_ccd_q, n_ccd_q) : load_of(n_ccd_q, n_rd2wr_q);
    rd_ld_val  = do_read  ? load_of(n_ccd_q, n_ccd_q) : load_of(n_ccd_q, n_wr2rd_q);
    last_dir_d = do_write ? DIR_WR : (do_read ? DIR_RD : last_dir_q);
    turnaround_busy = (last_dir_q == DIR_WR) ? ~rd_zero : ~wr_zero;
  end

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      n_ccd_q    <= '0;
      n_wr2rd_q  <= '0;
      n_rd2wr_q  <= '0;
      last_dir_q <= DIR_RD;
    end else begin
      n_ccd_q    <= n_ccd_d;
      n_wr2rd_q  <= n_wr2rd_d;
      n_rd2wr_q  <= n_rd2wr_d;
      last_dir_q <= last_dir_d;
    end
  end

  alt_ddrx_gap_counter #(.WIDTH(GAP_CNT_WIDTH)) u_wr_gap (
    .clk      (ctl_clk),
    .rst      (ctl_reset),
    .load     (issue),
    .load_val (wr_ld_val),
    .zero     (wr_zero)
  );

  alt_ddrx_gap_counter #(.WIDTH(GAP_CNT_WIDTH)) u_rd_gap (
    .clk      (ctl_clk),
    .rst      (ctl_reset),
    .load     (issue),
    .load_val (rd_ld_val),
    .zero     (rd_zero)
  );

endmodule

// File: tb/tb_alt_ddrx_ddr3_rdwr_turnaround.sv
// Two instances: index 0 = half rate (DWIDTH_RATIO 4), 1 = full rate (2).
module tb_alt_ddrx_ddr3_rdwr_turnaround;

  logic ctl_clk = 1'b0;
  logic ctl_reset = 1'b1;
  logic [3:0] mem_tcl = 4'd6, mem_cas_wr_lat = 4'd5, mem_twtr = 4'd4;
  logic vh = 0, wh = 0, vf = 0, wf = 0;
  logic rdy_h, dw_h, dr_h, bsy_h, rdy_f, dw_f, dr_f, bsy_f;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int cyc; logic wr; } ev_t;
  ev_t qh[$];
  ev_t qf[$];

  always #5 ctl_clk = ~ctl_clk;
  always @(posedge ctl_clk) cyc <= cyc + 1;

  alt_ddrx_ddr3_rdwr_turnaround #(.DWIDTH_RATIO(4)) dut_h (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .mem_tcl(mem_tcl),
    .mem_cas_wr_lat(mem_cas_wr_lat), .mem_twtr(mem_twtr),
    .cmd_valid(vh), .cmd_is_write(wh), .cmd_ready(rdy_h),
    .do_write(dw_h), .do_read(dr_h), .turnaround_busy(bsy_h));

  alt_ddrx_ddr3_rdwr_turnaround #(.DWIDTH_RATIO(2)) dut_f (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .mem_tcl(mem_tcl),
    .mem_cas_wr_lat(mem_cas_wr_lat), .mem_twtr(mem_twtr),
    .cmd_valid(vf), .cmd_is_write(wf), .cmd_ready(rdy_f),
    .do_write(dw_f), .do_read(dr_f), .turnaround_busy(bsy_f));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pulse(input int w);
    return (w == 0) ? (dw_h | dr_h) : (dw_f | dr_f);
  endfunction

  function automatic logic rdy(input int w);
    return (w == 0) ? rdy_h : rdy_f;
  endfunction

  task automatic step_cyc();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v, input logic wr);
    if (w == 0) begin vh = v; wh = wr; end
    else        begin vf = v; wf = wr; end
  endtask

  task automatic push(input int w, input logic wr, input int c);
    ev_t e;
    e.cyc = c; e.wr = wr;
    if (w == 0) qh.push_back(e);
    else        qf.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step_cyc();
  endtask

  // Present a request, expect it issued at cycle c; returns one cycle
  // after the issue with the request withdrawn.
  task automatic issue(input int w, input logic wr, input int c, input string tag);
    bit seen;
    seen = 0;
    push(w, wr, c);
    drive(w, 1'b1, wr);
    for (int k = 0; k < 40; k++) begin
      @(negedge ctl_clk);
      if (pulse(w)) begin seen = 1; break; end
      chk({tag, "_stall_rdy"}, rdy(w), 0);
      step_cyc();
    end
    chk({tag, "_seen"}, seen, 1);
    step_cyc();
    drive(w, 1'b0, 1'b0);
  endtask

  // Scoreboard: every pulse must match the oldest expected issue.
  always @(negedge ctl_clk) begin
    ev_t e;
    chk("h_excl", dw_h & dr_h, 0);
    chk("f_excl", dw_f & dr_f, 0);
    if (dw_h | dr_h) begin
      chk("h_expected", qh.size() != 0, 1);
      if (qh.size() != 0) begin
        e = qh.pop_front();
        chk("h_cycle", cyc, e.cyc);
        chk("h_dir", dw_h, e.wr);
      end
    end
    if (dw_f | dr_f) begin
      chk("f_expected", qf.size() != 0, 1);
      if (qf.size() != 0) begin
        e = qf.pop_front();
        chk("f_cycle", cyc, e.cyc);
        chk("f_dir", dw_f, e.wr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    wf = 1'b1;
    idle(2);
    @(negedge ctl_clk);
    chk("rst_rdy_rd_h", rdy_h, 1);
    chk("rst_rdy_wr_f", rdy_f, 1);
    chk("rst_busy_h", bsy_h, 0);
    chk("rst_nopulse_h", dw_h | dr_h, 0);
    step_cyc();
    ctl_reset = 1'b0;
    wf = 1'b0;
    idle(3);

    // Half rate WR->RD: N = ceil(13/2) = 7
    t = cyc;
    issue(0, 1'b1, t, "hwr");
    push(0, 1'b0, t + 7);
    drive(0, 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) begin
      @(negedge ctl_clk);
      chk("wr2rd_rdy", rdy_h, 0);
      chk("wr2rd_busy", bsy_h, 1);
      step_cyc();
    end
    @(negedge ctl_clk);
    chk("wr2rd_busy_end", bsy_h, 0);
    chk("wr2rd_do_read", dr_h, 1);
    step_cyc();
    drive(0, 1'b0, 1'b0);
    idle(8);

    // Half rate RD->WR: N = ceil(7/2) = 4
    t = cyc;
    issue(0, 1'b0, t, "hrd");
    issue(0, 1'b1, t + 4, "hrd2wr");
    idle(10);

    // Full rate back-to-back writes every 4 cycles
    t = cyc;
    for (int k = 0; k < 4; k++) push(1, 1'b1, t + 4 * k);
    drive(1, 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) begin
      @(negedge ctl_clk);
      step_cyc();
    end
    drive(1, 1'b0, 1'b0);
    mem_tcl = 4'd5; mem_cas_wr_lat = 4'd5;
    idle(20);

    // Full rate RD->WR with CL=5, CWL=5: 6 cycles
    t = cyc;
    issue(1, 1'b0, t, "frd");
    issue(1, 1'b1, t + 6, "frd2wr");
    idle(20);

    // Clamp: CL=5, CWL=8 -> 3 raised to 4
    mem_cas_wr_lat = 4'd8;
    idle(3);
    t = cyc;
    issue(1, 1'b0, t, "crd");
    issue(1, 1'b1, t + 4, "clamp_wr");
    idle(20);

    // Reset in the middle of a WR->RD gap
    mem_tcl = 4'd6; mem_cas_wr_lat = 4'd5;
    idle(3);
    t = cyc;
    issue(0, 1'b1, t, "rwr");
    step_cyc();
    @(negedge ctl_clk);
    chk("pre_rst_busy", bsy_h, 1);
    chk("pre_rst_rdy", rdy_h, 0);
    step_cyc();
    ctl_reset = 1'b1;
    #1;
    chk("async_rst_rdy", rdy_h, 1);
    chk("async_rst_busy", bsy_h, 0);
    step_cyc();
    ctl_reset = 1'b0;
    issue(0, 1'b0, cyc, "post_rst_rd");
    idle(4);

    // Direction flip while stalled
    t = cyc;
    issue(0, 1'b1, t, "fwr");
    drive(0, 1'b1, 1'b0);
    @(negedge ctl_clk);
    chk("flip_rd_stall", rdy_h, 0);
    step_cyc();
    push(0, 1'b1, t + 2);
    drive(0, 1'b1, 1'b1);
    @(negedge ctl_clk);
    chk("flip_do_write", dw_h, 1);
    step_cyc();
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge ctl_clk);
      chk("no_pulse_idle", dw_h | dr_h, 0);
      step_cyc();
    end

    chk("sb_h_drained", qh.size(), 0);
    chk("sb_f_drained", qf.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_ddrx_ddr3_rdwr_turnaround.md
Name: alt_ddrx_ddr3_rdwr_turnaround

Overview:
- Upstream command-timing gate for the DDR3 ODT generator.
- Accepts read/write column-command requests from the arbiter over a valid/ready handshake.
- Releases them as single-cycle do_write / do_read pulses only when the DDR3 same-direction (tCCD) and turnaround (WR->RD, RD->WR) spacing rules are met.
- do_write / do_read drive the ODT generator and the command encoder directly.

Parameters:
- DWIDTH_RATIO, 2, 2 = full rate (1 mem clk per ctl_clk); 4 = half rate (2 mem clks per ctl_clk).
- TCL_BUS_WIDTH, 4, width of mem_tcl.
- CAS_WR_LAT_BUS_WIDTH, 4, width of mem_cas_wr_lat.
- TWTR_BUS_WIDTH, 4, width of mem_twtr.
- GAP_CNT_WIDTH, 6, width of the internal gap counters and thresholds.

Ports:
- ctl_clk  in  1  controller clock; the only clock.
- ctl_reset  in  1  asynchronous, active-high reset.
- mem_tcl  in  TCL_BUS_WIDTH  CAS latency (CL) in mem clocks; quasi-static.
- mem_cas_wr_lat  in  CAS_WR_LAT_BUS_WIDTH  CWL in mem clocks; quasi-static.
- mem_twtr  in  TWTR_BUS_WIDTH  tWTR in mem clocks; quasi-static.
- cmd_valid  in  1  request pending.
- cmd_is_write  in  1  1 = write, 0 = read; qualified by cmd_valid.
- cmd_ready  out  1  request may issue this cycle.
- do_write  out  1  single-cycle write issue pulse.
- do_read  out  1  single-cycle read issue pulse.
- turnaround_busy  out  1  opposite-direction gap still counting.

Behaviour:
- Interface: one clock, ctl_clk. Reset ctl_reset is asynchronous and active-high.
- Reset values: wr_gap_cnt = 0, rd_gap_cnt = 0, all registered thresholds = 0, last_dir = read.
  - Hence cmd_ready follows the combinational rule below, and do_write = do_read = 0 while no request is valid.
- Thresholds, in mem clocks; BL8 only, tCCD = 4:
  - T_CCD = 4.
  - T_WR2RD = CWL + 4 + tWTR.
  - T_RD2WR = CL + 6 - CWL. If this is below 4, clamp to 4; no wrap on underflow.
- Conversion to ctl clocks:
  - DWIDTH_RATIO = 2: N = T.
  - DWIDTH_RATIO = 4: N = ceil(T/2).
- All sums use GAP_CNT_WIDTH bits and saturate at all-ones.
- Thresholds are registered: one cycle of latency after a config change.
- Config inputs may only change while no command is in flight. No requirement applies to mid-traffic changes.
- cmd_ready = cmd_is_write ? (wr_gap_cnt == 0) : (rd_gap_cnt == 0). Combinational from registered counters; does not depend on cmd_valid.
- Issue rule:
  - do_write = cmd_valid & cmd_ready & cmd_is_write.
  - do_read = cmd_valid & cmd_ready & ~cmd_is_write.
  - do_write and do_read are never high together.
- Loading on issue in cycle t; a load value of N-1 means the next same-class issue is allowed at cycle t+N.
  - On write issue: wr_gap_cnt <= N_CCD-1; rd_gap_cnt <= max(N_CCD, N_WR2RD)-1.
  - On read issue: rd_gap_cnt <= N_CCD-1; wr_gap_cnt <= max(N_CCD, N_RD2WR)-1.
  - A loaded value of N-1 is floored at 0.
- Otherwise each nonzero counter decrements by 1 per cycle and holds at 0.
- last_dir updates on each issue.
- turnaround_busy = (last_dir == write) ? (rd_gap_cnt != 0) : (wr_gap_cnt != 0).
- Handshake: the requester holds cmd_valid and cmd_is_write stable until accepted. A direction change while stalled is permitted and is re-evaluated the same cycle.
- Back-to-back same direction: issues every N_CCD cycles (2 in half rate, 4 in full rate).
- Reset mid-gap: counters clear immediately and asynchronously; the next request issues on the first cycle after reset deasserts.

Decomposition:
- Shared package alt_ddrx_timing_pkg holds:
  - constant T_CCD_BL8 = 4;
  - constant BL8_HALF = 4 (the burst-length term in T_WR2RD);
  - constant RD2WR_EXTRA = 2;
  - function mem2ctl_cycles(T, DWIDTH_RATIO), which rounds up;
  - the GAP_CNT_WIDTH default.
- One natural sub-module: alt_ddrx_gap_counter. It is a loadable, saturating down-counter with a zero flag and is instantiated twice (write gap, read gap).

Test Plan:
- Half rate, CL=6, CWL=5, tWTR=4: write accepted at cycle 10 -> read held, cmd_ready=0 until cycle 17 (N_WR2RD=ceil(13/2)=7), do_read pulses at 17, turnaround_busy high cycles 11-16.
- Same config: read at cycle 10, then write request -> N_RD2WR=ceil(7/2)=4, do_write at cycle 14.
- Full rate, continuous valid writes -> do_write pulses at 0, 4, 8, 12; no do_read; read then write with CL=5, CWL=5 -> T_RD2WR=6 (above the clamp of 4), do_write 6 cycles after do_read.
- Clamp: CL=5, CWL=8, full rate -> RD2WR is 3, clamped to 4, so the write follows the read after exactly 4 cycles.
- Pulse ctl_reset two cycles after a write while rd_gap_cnt=5 -> counters 0 asynchronously; a pending read issues on the first cycle after reset deasserts.
- Direction flip while stalled: a read waits, then cmd_is_write switches to 1 -> do_write issues as soon as wr_gap_cnt==0; a pulse never appears while cmd_valid=0.
